// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types for the MAC input sequencer.
// FSM state encoding and sticky error bit positions.
package mac_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;

endpackage

// File: rtl/mac_seq_counter.sv
// Wrapping up-counter with a terminal-count flag at LIMIT-1.
// Clear has priority over increment.
module mac_seq_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Streams J jobs of I beats into the MAC, waits for each beta result
// and holds it for a valid/ready consumer before starting the next job.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int J       = 14,
    parameter int I       = 7,
    parameter int A       = 2,
    parameter int TIMEOUT = 64,
    localparam int J_WIDTH  = $clog2(J) + 1,
    localparam int B_WIDTH  = $clog2(I) + 1,
    localparam int VA_WIDTH = $clog2(J * I)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic                v_rd_en,
    output logic [VA_WIDTH-1:0] v_addr,
    input  logic [31:0]         v_rdata,
    output logic                m_rd_en,
    output logic [B_WIDTH-1:0]  m_addr,
    input  logic [A-1:0]        m_rdata,
    output logic [31:0]         mac_vinput,
    output logic                mac_vinput_tvalid,
    output logic                mac_M_row_tvalid,
    output logic                mac_vinput_tlast,
    output logic                mac_M_row_tlast,
    output logic [A-1:0]        mac_M_row,
    input  logic                mac_beta_tvalid,
    input  logic [A*8-1:0]      mac_beta,
    output logic [A*8-1:0]      out_tdata,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic                out_tlast,
    output logic [J_WIDTH-1:0]  out_job
);

    localparam int W_WIDTH = $clog2(TIMEOUT) + 1;

    state_t               state;
    logic [B_WIDTH-1:0]   beat;
    logic                 beat_tc;
    logic [J_WIDTH-1:0]   job;
    logic                 job_tc;
    logic [W_WIDTH-1:0]   unused_wait_cnt;
    logic                 wait_tc;
    logic                 out_hs;
    logic                 stream_valid;
    logic                 stream_last;

    assign busy    = (state != IDLE);
    assign v_rd_en = (state == ISSUE);
    assign m_rd_en = v_rd_en;
    assign m_addr  = beat;
    assign v_addr  = VA_WIDTH'(job) * VA_WIDTH'(I) + VA_WIDTH'(beat);
    assign out_hs  = (state == HOLD) && out_tvalid && out_tready;

    assign mac_vinput        = v_rdata;
    assign mac_M_row         = m_rdata;
    assign mac_vinput_tvalid = stream_valid;
    assign mac_M_row_tvalid  = stream_valid;
    assign mac_vinput_tlast  = stream_last;
    assign mac_M_row_tlast   = stream_last;

    // beat wraps to 0 after the last read, so HOLD->ISSUE needs no clear
    mac_seq_counter #(.W(B_WIDTH), .LIMIT(I)) u_beat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .inc   (v_rd_en),
        .cnt   (beat),
        .tc    (beat_tc)
    );

    mac_seq_counter #(.W(J_WIDTH), .LIMIT(J)) u_job (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .inc   (out_hs && !job_tc),
        .cnt   (job),
        .tc    (job_tc)
    );

    mac_seq_counter #(.W(W_WIDTH), .LIMIT(TIMEOUT)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != WAIT),
        .inc   (state == WAIT),
        .cnt   (unused_wait_cnt),
        .tc    (wait_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            done         <= 1'b0;
            err          <= '0;
            out_tvalid   <= 1'b0;
            out_tdata    <= '0;
            out_tlast    <= 1'b0;
            out_job      <= '0;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
        end else begin
            done         <= 1'b0;
            stream_valid <= v_rd_en;
            stream_last  <= v_rd_en && beat_tc;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (beat_tc) state <= WAIT;
                end
                WAIT: begin
                    if (mac_beta_tvalid) begin
                        out_tdata  <= mac_beta;
                        out_job    <= job;
                        out_tlast  <= job_tc;
                        out_tvalid <= 1'b1;
                        state      <= HOLD;
                    end else if (wait_tc) begin
                        err[ERR_TIMEOUT] <= 1'b1;
                        done             <= 1'b1;
                        state            <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_hs) begin
                        out_tvalid <= 1'b0;
                        if (job_tc) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // a beta outside WAIT still flags even on the clearing start
            if (mac_beta_tvalid && state != WAIT) err[ERR_SPURIOUS] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with memory and MAC models
// and a scoreboard of expected addresses, stream markers and results.
module tb_mac_seq_ctrl;

    localparam int J  = 2;
    localparam int I  = 3;
    localparam int A  = 2;
    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        v_rd_en;
    logic [2:0]  v_addr;
    logic [31:0] v_rdata;
    logic        m_rd_en;
    logic [2:0]  m_addr;
    logic [1:0]  m_rdata;
    logic [31:0] mac_vinput;
    logic        mac_vinput_tvalid;
    logic        mac_M_row_tvalid;
    logic        mac_vinput_tlast;
    logic        mac_M_row_tlast;
    logic [1:0]  mac_M_row;
    logic        mac_beta_tvalid;
    logic [15:0] mac_beta;
    logic [15:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic [1:0]  out_job;

    logic        mac_vld;
    logic [15:0] mac_beta_r;
    logic        spur;
    logic        mac_en;
    logic [7:0]  acc0, acc1;
    logic [15:0] res;
    int          lat;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] obs_addr[$];
    logic        obs_last[$];
    logic [31:0] exp_res[$];
    logic [31:0] obs_res[$];

    assign mac_beta_tvalid = mac_vld | spur;
    assign mac_beta        = spur ? 16'hDEAD : mac_beta_r;

    mac_seq_ctrl #(.J(J), .I(I), .A(A), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .v_rd_en           (v_rd_en),
        .v_addr            (v_addr),
        .v_rdata           (v_rdata),
        .m_rd_en           (m_rd_en),
        .m_addr            (m_addr),
        .m_rdata           (m_rdata),
        .mac_vinput        (mac_vinput),
        .mac_vinput_tvalid (mac_vinput_tvalid),
        .mac_M_row_tvalid  (mac_M_row_tvalid),
        .mac_vinput_tlast  (mac_vinput_tlast),
        .mac_M_row_tlast   (mac_M_row_tlast),
        .mac_M_row         (mac_M_row),
        .mac_beta_tvalid   (mac_beta_tvalid),
        .mac_beta          (mac_beta),
        .out_tdata         (out_tdata),
        .out_tvalid        (out_tvalid),
        .out_tready        (out_tready),
        .out_tlast         (out_tlast),
        .out_job           (out_job)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] vmem(input logic [2:0] a);
        logic [7:0] lo;
        lo = 8'(int'(a) * 13 + 5);
        return {24'hC0FFEE, lo};
    endfunction

    function automatic logic [15:0] exp_beta(input int j);
        logic [7:0] l0, l1, vb;
        logic [1:0] m;
        l0 = 8'd0;
        l1 = 8'd0;
        for (int b = 0; b < I; b++) begin
            vb = 8'((j * I + b) * 13 + 5);
            m  = 2'(b + 1);
            if (m[0]) l0 = l0 + vb;
            if (m[1]) l1 = l1 + vb;
        end
        return {l1, l0};
    endfunction

    always @(posedge clk) begin
        if (v_rd_en) v_rdata <= vmem(v_addr);
        if (m_rd_en) m_rdata <= 2'(m_addr + 3'd1);
    end

    // MAC model: per-lane 8-bit accumulate, result 5 cycles after tlast
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0       <= 8'd0;
            acc1       <= 8'd0;
            lat        <= 0;
            mac_vld    <= 1'b0;
            mac_beta_r <= 16'd0;
            res        <= 16'd0;
        end else begin
            mac_vld <= 1'b0;
            if (lat != 0) begin
                lat <= lat - 1;
                if (lat == 1) begin
                    mac_vld    <= 1'b1;
                    mac_beta_r <= res;
                end
            end
            if (mac_vinput_tvalid) begin
                if (mac_vinput_tlast) begin
                    res <= {acc1 + (mac_M_row[1] ? mac_vinput[7:0] : 8'd0),
                            acc0 + (mac_M_row[0] ? mac_vinput[7:0] : 8'd0)};
                    acc0 <= 8'd0;
                    acc1 <= 8'd0;
                    if (mac_en) lat <= 5;
                end else begin
                    acc0 <= acc0 + (mac_M_row[0] ? mac_vinput[7:0] : 8'd0);
                    acc1 <= acc1 + (mac_M_row[1] ? mac_vinput[7:0] : 8'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (v_rd_en) begin
                obs_addr.push_back(32'(v_addr));
                rd_cnt++;
            end
            if (mac_vinput_tvalid) obs_last.push_back(mac_vinput_tlast);
            if (out_tvalid && out_tready)
                obs_res.push_back({13'd0, out_tlast, out_job, out_tdata});
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_addr.delete();
        obs_addr.delete();
        obs_last.delete();
        exp_res.delete();
        obs_res.delete();
    endtask

    task automatic push_run();
        for (int j = 0; j < J; j++) begin
            for (int b = 0; b < I; b++) exp_addr.push_back(32'(j * I + b));
            exp_res.push_back({13'd0, (j == J - 1), 2'(j), exp_beta(j)});
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 300) begin
            step();
            n++;
        end
        chk(tag, 32'(done_cnt), 32'(base + 1));
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_naddr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        while (exp_addr.size() > 0 && obs_addr.size() > 0)
            chk({tag, "_addr"}, obs_addr.pop_front(), exp_addr.pop_front());
        chk({tag, "_nbeat"}, 32'(obs_last.size()), 32'(J * I));
        for (int k = 0; obs_last.size() > 0; k++)
            chk({tag, "_tlast"}, 32'(obs_last.pop_front()),
                32'((k % I) == I - 1));
        chk({tag, "_nres"}, 32'(obs_res.size()), 32'(exp_res.size()));
        while (exp_res.size() > 0 && obs_res.size() > 0)
            chk({tag, "_res"}, obs_res.pop_front(), exp_res.pop_front());
        clear_q();
    endtask

    initial begin
        int base;
        int n;
        logic [15:0] hd;
        logic [1:0]  hj;
        start      = 1'b0;
        out_tready = 1'b1;
        spur       = 1'b0;
        mac_en     = 1'b1;
        rst_n      = 1'b0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rd", 32'(v_rd_en), 0);
        chk("rst_vaddr", 32'(v_addr), 0);
        chk("rst_tvalid", 32'(out_tvalid), 0);
        chk("rst_svalid", 32'(mac_vinput_tvalid), 0);
        rst_n = 1'b1;
        step();

        // normal run
        clear_q();
        push_run();
        base = done_cnt;
        do_start();
        chk("first_rd", 32'(v_rd_en), 1);
        chk("first_addr", 32'(v_addr), 0);
        wait_done("norm_done", base);
        repeat (3) step();
        chk("norm_done_once", 32'(done_cnt), 32'(base + 1));
        chk("norm_err", 32'(err), 0);
        chk("norm_busy", 32'(busy), 0);
        check_run("norm");

        // backpressure on the first result
        push_run();
        out_tready = 1'b0;
        base = done_cnt;
        do_start();
        n = 0;
        while (!out_tvalid && n < 100) begin
            step();
            n++;
        end
        chk("bp_tvalid", 32'(out_tvalid), 1);
        hd = out_tdata;
        hj = out_job;
        n  = rd_cnt;
        chk("bp_data", 32'(hd), 32'(exp_beta(0)));
        chk("bp_job", 32'(hj), 0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_stable_data", 32'(out_tdata), 32'(hd));
            chk("bp_stable_job", 32'(out_job), 32'(hj));
        end
        chk("bp_no_reads", 32'(rd_cnt), 32'(n));
        out_tready = 1'b1;
        wait_done("bp_done", base);
        check_run("bp");

        // timeout
        mac_en = 1'b0;
        base = done_cnt;
        do_start();
        n = 0;
        while (!(v_rd_en && v_addr == 3'd2) && n < 20) begin
            step();
            n++;
        end
        chk("to_last_rd", 32'(v_addr), 2);
        step();
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("to_latency", 32'(n), 32'(TO));
        chk("to_err", 32'(err), 32'h1);
        chk("to_busy", 32'(busy), 0);
        chk("to_tvalid", 32'(out_tvalid), 0);
        step();
        chk("to_done_cnt", 32'(done_cnt), 32'(base + 1));
        mac_en = 1'b1;
        base = done_cnt;
        do_start();
        chk("to_err_clr", 32'(err), 0);
        chk("to_restart", 32'(busy), 1);
        wait_done("to_rerun_done", base);
        clear_q();

        // spurious beta during ISSUE
        push_run();
        base = done_cnt;
        do_start();
        spur = 1'b1;
        step();
        spur = 1'b0;
        wait_done("sp_done", base);
        chk("sp_err", 32'(err), 32'h2);
        check_run("sp");

        // reset at beat 1
        base = done_cnt;
        do_start();
        step();
        chk("rs_addr1", 32'(v_addr), 1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 0);
        chk("rs_rd", 32'(v_rd_en), 0);
        chk("rs_vaddr", 32'(v_addr), 0);
        chk("rs_svalid", 32'(mac_vinput_tvalid), 0);
        chk("rs_slast", 32'(mac_vinput_tlast), 0);
        chk("rs_tvalid", 32'(out_tvalid), 0);
        chk("rs_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rs_no_done", 32'(done_cnt), 32'(base));
        clear_q();
        push_run();
        do_start();
        chk("rs_restart_addr", 32'(v_addr), 0);
        wait_done("rs_done2", base);
        check_run("rs");

        // start while busy
        push_run();
        base = done_cnt;
        do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("sb_done", base);
        repeat (4) step();
        chk("sb_idle", 32'(busy), 0);
        chk("sb_done_once", 32'(done_cnt), 32'(base + 1));
        check_run("sb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
